// File: rtl/elevator_pkg.sv
// -----------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator scheduler:
//   state_e            - 2-bit controller state (IDLE/MOVE_UP/MOVE_DN/DOOR)
//   DEF_TICK_PER_SEC   - default clk cycles per second (10 kHz clock)
//   DEF_TRAVEL_SEC     - default seconds per one-floor move
//   DEF_DOOR_SEC       - default seconds the door stays open
// -----------------------------------------------------------------------------
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2,
        DOOR    = 2'd3
    } state_e;

    localparam int DEF_TICK_PER_SEC = 10000;
    localparam int DEF_TRAVEL_SEC   = 5;
    localparam int DEF_DOOR_SEC     = 5;

endpackage

// File: rtl/sec_timer.sv
// -----------------------------------------------------------------------------
// sec_timer
// Whole-second period timer built from a cycle prescaler and a seconds count.
// A load sets the prescaler to 0 and the seconds count to load_val; the count
// then reads N, N-1, ..., 1 and the period lasts exactly N*TICK_PER_SEC cycles.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   load, load_val  - start a new period of load_val seconds
//   sec_left        - whole seconds remaining (0 when idle)
//   expire          - high in the last cycle of the period
// -----------------------------------------------------------------------------
module sec_timer #(
    parameter int TICK_PER_SEC = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] sec_left,
    output logic       expire
);

    localparam int PW = (TICK_PER_SEC > 1) ? $clog2(TICK_PER_SEC) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_PER_SEC - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sec_q, sec_d;
    logic          wrap;

    // The prescaler only advances while a period is running, so it sits at 0
    // whenever the timer is idle.
    assign wrap   = (presc_q == PS_LAST) && (sec_q != 4'd0);
    assign expire = wrap && (sec_q == 4'd1);

    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        if (load) begin
            presc_d = '0;
            sec_d   = load_val;
        end else if (sec_q != 4'd0) begin
            if (wrap) begin
                presc_d = '0;
                sec_d   = sec_q - 4'd1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            sec_q   <= 4'd0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
        end
    end

    assign sec_left = sec_q;

endmodule

// File: rtl/elevator_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_scheduler
// N-floor elevator controller: latches one-shot floor requests, serves them
// with a same-direction-first (SCAN) policy, times floor-to-floor moves and
// door-open periods, and drives the stepper motor enable and direction.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   req_shot     - one-cycle request pulses, bit f = floor f
//   state        - 0=IDLE 1=MOVE_UP 2=MOVE_DN 3=DOOR
//   cur_floor    - current floor, 0-based
//   pending      - latched unserved requests
//   sec_left     - seconds remaining in current move/door period
//   motor_onoff  - motor enabled while moving
//   motor_dir    - 1 = up; holds last travel direction when stopped
//
// state   | meaning
// IDLE    | parked at cur_floor, waiting for a pending request
// MOVE_UP | travelling one floor up, timer running TRAVEL_SEC
// MOVE_DN | travelling one floor down, timer running TRAVEL_SEC
// DOOR    | door open at cur_floor, timer running DOOR_SEC
// -----------------------------------------------------------------------------
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int FLOORS       = 3,
    parameter int TICK_PER_SEC = DEF_TICK_PER_SEC,
    parameter int TRAVEL_SEC   = DEF_TRAVEL_SEC,
    parameter int DOOR_SEC     = DEF_DOOR_SEC,
    localparam int FW          = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] req_shot,
    output logic [1:0]        state,
    output logic [FW-1:0]     cur_floor,
    output logic [FLOORS-1:0] pending,
    output logic [3:0]        sec_left,
    output logic              motor_onoff,
    output logic              motor_dir
);

    state_e            state_q, state_d;
    logic [FW-1:0]     cur_q, cur_d, nxt_floor;
    logic [FLOORS-1:0] pend_q, pend_d, pend_set, pend_clr;
    logic              dir_up_q, dir_up_d;

    logic [FLOORS-1:0] cur_oh, nxt_oh;
    logic [FLOORS-1:0] above_cur, below_cur, above_nxt, below_nxt;
    logic              any_above, any_below, go_up, further;

    logic              tmr_load, tmr_expire;
    logic [3:0]        tmr_val;

    // Floor the car reaches when the current move expires. Only meaningful
    // while moving; the scheduler never starts a move past either end.
    assign nxt_floor = (state_q == MOVE_DN) ? cur_q - 1'b1 : cur_q + 1'b1;

    for (genvar f = 0; f < FLOORS; f++) begin : g_search
        assign cur_oh[f]    = (cur_q == FW'(f));
        assign nxt_oh[f]    = (nxt_floor == FW'(f));
        assign above_cur[f] = pend_q[f] && (FW'(f) > cur_q);
        assign below_cur[f] = pend_q[f] && (FW'(f) < cur_q);
        assign above_nxt[f] = pend_q[f] && (FW'(f) > nxt_floor);
        assign below_nxt[f] = pend_q[f] && (FW'(f) < nxt_floor);
    end

    assign any_above = |above_cur;
    assign any_below = |below_cur;
    assign go_up     = any_above && (dir_up_q || !any_below);
    assign further   = (state_q == MOVE_UP) ? |above_nxt : |below_nxt;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        dir_up_d = dir_up_q;
        tmr_load = 1'b0;
        tmr_val  = 4'(TRAVEL_SEC);
        pend_set = req_shot;
        pend_clr = '0;

        case (state_q)
            IDLE: begin
                if (|(req_shot & cur_oh)) begin
                    pend_set = req_shot & ~cur_oh;
                    state_d  = DOOR;
                    tmr_load = 1'b1;
                    tmr_val  = 4'(DOOR_SEC);
                end else if (|(pend_q & cur_oh)) begin
                    // Not normally reachable; serve it rather than wander.
                    pend_clr = cur_oh;
                    state_d  = DOOR;
                    tmr_load = 1'b1;
                    tmr_val  = 4'(DOOR_SEC);
                end else if (|pend_q) begin
                    state_d  = go_up ? MOVE_UP : MOVE_DN;
                    dir_up_d = go_up;
                    tmr_load = 1'b1;
                end
            end

            MOVE_UP, MOVE_DN: begin
                if (tmr_expire) begin
                    cur_d = nxt_floor;
                    // A request for the arrival floor in the arrival cycle is
                    // absorbed by the stop instead of being latched.
                    if (|((pend_q | req_shot) & nxt_oh)) begin
                        pend_set = req_shot & ~nxt_oh;
                        pend_clr = nxt_oh;
                        state_d  = DOOR;
                        tmr_load = 1'b1;
                        tmr_val  = 4'(DOOR_SEC);
                    end else if (further) begin
                        tmr_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            DOOR: begin
                if (|(req_shot & cur_oh)) begin
                    pend_set = req_shot & ~cur_oh;
                    tmr_load = 1'b1;
                    tmr_val  = 4'(DOOR_SEC);
                end else if (tmr_expire) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        pend_d = (pend_q | pend_set) & ~pend_clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            pend_q   <= '0;
            dir_up_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
            dir_up_q <= dir_up_d;
        end
    end

    sec_timer #(
        .TICK_PER_SEC (TICK_PER_SEC)
    ) u_sec_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .sec_left (sec_left),
        .expire   (tmr_expire)
    );

    assign state       = state_q;
    assign cur_floor   = cur_q;
    assign pending     = pend_q;
    assign motor_onoff = (state_q == MOVE_UP) || (state_q == MOVE_DN);
    assign motor_dir   = dir_up_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// -----------------------------------------------------------------------------
// tb_elevator_scheduler
// Directed bench for elevator_scheduler with FLOORS=4, TICK_PER_SEC=4,
// TRAVEL_SEC=2, DOOR_SEC=3 (one move = 8 cycles, one door period = 12 cycles).
// -----------------------------------------------------------------------------
module tb_elevator_scheduler;

    localparam int FLOORS = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [FLOORS-1:0] req_shot;
    logic [1:0]        state;
    logic [1:0]        cur_floor;
    logic [FLOORS-1:0] pending;
    logic [3:0]        sec_left;
    logic              motor_onoff;
    logic              motor_dir;

    int n_tests = 0;
    int n_fail  = 0;

    elevator_scheduler #(
        .FLOORS       (FLOORS),
        .TICK_PER_SEC (4),
        .TRAVEL_SEC   (2),
        .DOOR_SEC     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_shot    (req_shot),
        .state       (state),
        .cur_floor   (cur_floor),
        .pending     (pending),
        .sec_left    (sec_left),
        .motor_onoff (motor_onoff),
        .motor_dir   (motor_dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [FLOORS-1:0] mask);
        req_shot = mask;
        step(1);
        req_shot = '0;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int n = 0;
        while (state !== s && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n;

        rst      = 1'b1;
        req_shot = '0;
        step(3);
        rst = 1'b0;

        // Reset then idle
        chk("rst_state", 32'(state), 0);
        chk("rst_floor", 32'(cur_floor), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_sec", 32'(sec_left), 0);
        chk("rst_onoff", 32'(motor_onoff), 0);
        chk("rst_dir", 32'(motor_dir), 1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (state !== 2'd0 || cur_floor !== 2'd0 || pending !== 4'd0 ||
                motor_onoff !== 1'b0 || motor_dir !== 1'b1 || sec_left !== 4'd0)
                bad++;
        end
        chk("idle_hold", 32'(bad), 0);

        // Single trip 0 -> 3
        pulse(4'b1000);
        chk("trip_pending", 32'(pending), 8);
        chk("trip_still_idle", 32'(state), 0);
        step(1);
        chk("trip_state_up", 32'(state), 1);
        chk("trip_onoff", 32'(motor_onoff), 1);
        chk("trip_sec_load", 32'(sec_left), 2);
        step(4);
        chk("trip_sec_dec", 32'(sec_left), 1);
        step(4);
        chk("trip_floor1", 32'(cur_floor), 1);
        step(8);
        chk("trip_floor2", 32'(cur_floor), 2);
        step(8);
        chk("trip_floor3", 32'(cur_floor), 3);
        chk("trip_door", 32'(state), 3);
        chk("trip_door_sec3", 32'(sec_left), 3);
        chk("trip_pend_clr", 32'(pending), 0);
        chk("trip_motor_off", 32'(motor_onoff), 0);
        chk("trip_dir_hold", 32'(motor_dir), 1);
        step(4);
        chk("trip_door_sec2", 32'(sec_left), 2);
        step(4);
        chk("trip_door_sec1", 32'(sec_left), 1);
        step(3);
        chk("trip_door_last", 32'(state), 3);
        step(1);
        chk("trip_idle", 32'(state), 0);
        chk("trip_idle_sec", 32'(sec_left), 0);

        // Travel 3 -> 1
        pulse(4'b0010);
        step(1);
        chk("down_state", 32'(state), 2);
        chk("down_dir", 32'(motor_dir), 0);
        wait_state(2'd3, 40, "down_door");
        chk("down_floor", 32'(cur_floor), 1);
        wait_state(2'd0, 40, "down_idle");

        // Same-floor call and door restart
        pulse(4'b0010);
        chk("same_door", 32'(state), 3);
        chk("same_sec", 32'(sec_left), 3);
        chk("same_pending", 32'(pending), 0);
        step(9);
        chk("same_sec_before", 32'(sec_left), 1);
        pulse(4'b0010);
        chk("restart_sec", 32'(sec_left), 3);
        chk("restart_state", 32'(state), 3);
        chk("restart_pending", 32'(pending), 0);
        step(11);
        chk("restart_still_door", 32'(state), 3);
        step(1);
        chk("restart_idle", 32'(state), 0);

        // Travel 1 -> 2 (leaves dir_up = 1)
        pulse(4'b0100);
        step(1);
        chk("up2_state", 32'(state), 1);
        wait_state(2'd3, 40, "up2_door");
        chk("up2_floor", 32'(cur_floor), 2);
        wait_state(2'd0, 40, "up2_idle");

        // SCAN order from floor 2 with requests at 0 and 3
        pulse(4'b1001);
        chk("scan_pending", 32'(pending), 9);
        step(1);
        chk("scan_first_up", 32'(state), 1);
        chk("scan_dir_up", 32'(motor_dir), 1);
        wait_state(2'd3, 40, "scan_door3");
        chk("scan_floor3", 32'(cur_floor), 3);
        chk("scan_pend_after3", 32'(pending), 1);
        wait_state(2'd2, 40, "scan_move_dn");
        chk("scan_dir_dn", 32'(motor_dir), 0);
        wait_state(2'd3, 60, "scan_door0");
        chk("scan_floor0", 32'(cur_floor), 0);
        chk("scan_pend_done", 32'(pending), 0);
        wait_state(2'd0, 40, "scan_idle");

        // Arrival collision at floor 2 on the way to floor 3
        pulse(4'b1000);
        step(1);
        chk("coll_up", 32'(state), 1);
        step(15);
        chk("coll_pre_floor", 32'(cur_floor), 1);
        chk("coll_pre_state", 32'(state), 1);
        req_shot = 4'b0100;
        step(1);
        req_shot = '0;
        chk("coll_door", 32'(state), 3);
        chk("coll_floor", 32'(cur_floor), 2);
        chk("coll_pending", 32'(pending), 8);

        // Reset mid-move (heading for floor 3 after the door closes)
        n = 0;
        while (!(state == 2'd1 && sec_left == 4'd1) && n < 100) begin
            step(1);
            n++;
        end
        chk("mid_reached", 32'(state == 2'd1 && sec_left == 4'd1), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", 32'(state), 0);
        chk("mid_rst_floor", 32'(cur_floor), 0);
        chk("mid_rst_pending", 32'(pending), 0);
        chk("mid_rst_sec", 32'(sec_left), 0);
        chk("mid_rst_onoff", 32'(motor_onoff), 0);
        chk("mid_rst_dir", 32'(motor_dir), 1);
        step(2);
        rst = 1'b0;
        step(20);
        chk("post_rst_state", 32'(state), 0);
        chk("post_rst_floor", 32'(cur_floor), 0);
        chk("post_rst_onoff", 32'(motor_onoff), 0);
        chk("post_rst_pending", 32'(pending), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
